// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle between the WB stage, the long-latency return path, decode and
// the register-file write port.
interface regfile_wb_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  a_wen;
  logic [ADDR_WIDTH-1:0] a_waddr;
  logic [DATA_WIDTH-1:0] a_wdata;
  logic                  b_valid;
  logic [ADDR_WIDTH-1:0] b_waddr;
  logic [DATA_WIDTH-1:0] b_wdata;
  logic                  b_ready;
  logic                  issue_valid;
  logic [ADDR_WIDTH-1:0] issue_addr;
  logic [ADDR_WIDTH-1:0] raddr1;
  logic [ADDR_WIDTH-1:0] raddr2;
  logic                  busy1;
  logic                  busy2;
  logic                  stall_pipe;
  logic                  rf_wen;
  logic [ADDR_WIDTH-1:0] rf_waddr;
  logic [DATA_WIDTH-1:0] rf_wdata;

  modport slave (
    input  a_wen, a_waddr, a_wdata, b_valid, b_waddr, b_wdata,
           issue_valid, issue_addr, raddr1, raddr2,
    output b_ready, busy1, busy2, stall_pipe, rf_wen, rf_waddr, rf_wdata
  );

  modport master (
    output a_wen, a_waddr, a_wdata, b_valid, b_waddr, b_wdata,
           issue_valid, issue_addr, raddr1, raddr2,
    input  b_ready, busy1, busy2, stall_pipe, rf_wen, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: WB stage (A) vs long-latency return (B),
// with a starvation guard that freezes the pipe and a per-register busy scoreboard.
module regfile_wb_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  regfile_wb_arbiter_if.slave bus
);
  localparam int         NUM_REGS   = 2**ADDR_WIDTH;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic {NORMAL, STARVE} state_t;

  state_t              r_state;
  logic [3:0]          r_starve_cnt;
  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_nxt;
  logic [3:0]          w_cnt_inc;
  logic                w_grant_a;
  logic                w_grant_b;
  logic                w_denied;

  // Grants are gated by rst so the write port is quiet the instant reset rises.
  assign w_grant_a = !rst && (r_state == NORMAL) && bus.a_wen;
  assign w_grant_b = !rst && bus.b_valid && ((r_state == STARVE) || !bus.a_wen);
  assign w_denied  = (r_state == NORMAL) && bus.b_valid && bus.a_wen;
  assign w_cnt_inc = (r_starve_cnt == 4'hF) ? r_starve_cnt : r_starve_cnt + 4'd1;

  assign bus.b_ready    = w_grant_b;
  assign bus.stall_pipe = (r_state == STARVE);
  assign bus.rf_wen     = w_grant_a || w_grant_b;
  assign bus.rf_waddr   = w_grant_b ? bus.b_waddr : bus.a_waddr;
  assign bus.rf_wdata   = w_grant_b ? bus.b_wdata : bus.a_wdata;

  // STARVE always lasts one cycle: either B hands off or B has gone away.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= NORMAL;
      r_starve_cnt <= '0;
    end else if (r_state == STARVE) begin
      r_state      <= NORMAL;
      r_starve_cnt <= '0;
    end else if (w_grant_b) begin
      r_starve_cnt <= '0;
    end else if (w_denied) begin
      r_starve_cnt <= w_cnt_inc;
      if (w_cnt_inc >= STARVE_LIM) r_state <= STARVE;
    end
  end

  // Issue is applied after completion so a same-address pair leaves the bit set.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_grant_b) w_busy_nxt[bus.b_waddr] = 1'b0;
    if (bus.issue_valid) w_busy_nxt[bus.issue_addr] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_busy <= '0;
    else     r_busy <= w_busy_nxt;
  end

  assign bus.busy1 = r_busy[bus.raddr1];
  assign bus.busy2 = r_busy[bus.raddr2];
endmodule
